wb_stage: RTL
=============

# wb_stage

Writeback stage of the MangoMIPS five-stage pipeline. It registers results leaving the MEM stage, formats load data returned by the synchronous data memory (byte/half extraction, sign/zero extension), and drives the register file write port (we/waddr/wdata). It also holds load data across pipeline stalls, because the data memory presents read data for only one cycle.

## Interface
Parameters:
- None. Data width is fixed at 32 bits and register address width at 5 bits, matching the register file.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- stall  in  1  hold the WB register contents this cycle.
- flush  in  1  load a bubble into WB at the next edge.
- m_we  in  1  MEM-stage instruction writes a GPR.
- m_waddr  in  5  destination GPR.
- m_alures  in  32  non-load result.
- m_memop  in  3  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW; 6 and 7 are treated as NONE.
- m_addrlo  in  2  load address bits [1:0].
- d_rdata  in  32  data memory read word, valid in the first cycle an instruction occupies WB.
- wb_we  out  1  register file write enable.
- wb_waddr  out  5  register file write address.
- wb_wdata  out  32  register file write data.
- wb_adel  out  1  misaligned load detected; its write is suppressed.

## Operation
- Internal registers: valid, we, waddr[4:0], alures[31:0], memop[2:0], addrlo[1:0], hold_data[31:0], held.
- Register update priority at each rising edge: flush, then stall, then normal advance.
  - flush: valid=0, we=0, held=0. Other fields are don't-care.
  - stall with no flush: all fields keep their values. If valid, memop is a load, and held=0, then hold_data<=d_rdata and held<=1.
  - normal advance: valid<=1, m_* fields are captured, held<=0.
- Load data source: ld = held ? hold_data : d_rdata.
- Extraction is little-endian:
  - LB/LBU select byte ld[8*addrlo+7 : 8*addrlo]. LB sign-extends it; LBU zero-extends it.
  - LH/LHU select addrlo[1] ? ld[31:16] : ld[15:0], then sign-extend or zero-extend.
  - LW uses ld unchanged.
- Misalignment: adel = valid & ((LH|LHU) & addrlo[0] | LW & (addrlo != 0)).
- Outputs (combinational from registers and d_rdata):
  - wb_wdata = load ? extracted value : alures.
  - wb_we = valid & we & ~adel & (waddr != 0).
  - wb_waddr = waddr.
  - wb_adel = adel.
- While stalled, a valid instruction keeps wb_we and wb_wdata stable. Rewriting the same value is harmless.

## Timing
- Reset (rst=0, asynchronous): every internal register clears to 0. Outputs go to wb_we=0, wb_waddr=0, wb_wdata=0, wb_adel=0 immediately, independent of clk.
- Latency: the cycle after a MEM instruction advances, its write is presented to the register file. The register file commits it at the following edge and bypasses it combinationally in the same cycle.
- d_rdata is sampled only in the first WB cycle of a load. Later stalled cycles ignore d_rdata.
- flush and stall together: flush wins. The bubble enters and held clears.
- Reset mid-stall discards held data. No write happens after reset is released until a new instruction advances.
- Back-to-back loads without stall: each uses live d_rdata. held stays 0.

## Test plan
- ALU write: m_we=1, m_waddr=5, m_alures=0x00001234, m_memop=0, then one edge -> wb_we=1, wb_waddr=5, wb_wdata=0x00001234.
- Byte loads: LB with addrlo=2 and d_rdata=0x0080FF00 -> wb_wdata=0xFFFFFF80. LBU with the same inputs -> 0x00000080.
- Half loads: LH with addrlo=2 and d_rdata=0x80011234 -> 0xFFFF8001. LHU -> 0x00008001. LH with addrlo=0 -> 0x00001234.
- Stall hold: LW into r7 with d_rdata=0xCAFEF00D, stall=1 for 3 cycles, d_rdata changed to 0xDEADBEEF from cycle 2 onward -> wb_wdata stays 0xCAFEF00D and wb_we=1 throughout.
- Misaligned load and r0: LW with addrlo=1 -> wb_adel=1, wb_we=0. ALU write to waddr=0 -> wb_we=0.
- Flush and reset: flush=1 together with stall=1 -> next cycle wb_we=0 and held=0. rst=0 asserted mid-cycle during a held load -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: registers MEM results, formats load data, drives the GPR write port.
// Latency: one register stage; write presented the cycle after MEM advances.
// Backpressure: stall holds the stage and captures one-cycle load data; flush inserts a bubble.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        m_we,
    input  logic [4:0]  m_waddr,
    input  logic [31:0] m_alures,
    input  logic [2:0]  m_memop,
    input  logic [1:0]  m_addrlo,
    input  logic [31:0] d_rdata,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        wb_adel
);
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_LW  = 3'd5;

    logic        r_valid;
    logic        r_we;
    logic [4:0]  r_waddr;
    logic [31:0] r_alures;
    logic [2:0]  r_memop;
    logic [1:0]  r_addrlo;
    logic [31:0] r_hold_data;
    logic        r_held;

    logic        w_is_load;
    logic [31:0] w_ld;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic        w_adel;

    assign w_is_load = (r_memop >= OP_LB) && (r_memop <= OP_LW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_we        <= 1'b0;
            r_waddr     <= 5'd0;
            r_alures    <= 32'd0;
            r_memop     <= 3'd0;
            r_addrlo    <= 2'd0;
            r_hold_data <= 32'd0;
            r_held      <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_held  <= 1'b0;
        end else if (stall) begin
            // Memory drives read data for one cycle only; capture it on the first stalled edge.
            if (r_valid && w_is_load && !r_held) begin
                r_hold_data <= d_rdata;
                r_held      <= 1'b1;
            end
        end else begin
            r_valid  <= 1'b1;
            r_we     <= m_we;
            r_waddr  <= m_waddr;
            r_alures <= m_alures;
            r_memop  <= m_memop;
            r_addrlo <= m_addrlo;
            r_held   <= 1'b0;
        end
    end

    assign w_ld = r_held ? r_hold_data : d_rdata;

    always_comb begin
        w_byte = w_ld[7:0];
        case (r_addrlo)
            2'd0: w_byte = w_ld[7:0];
            2'd1: w_byte = w_ld[15:8];
            2'd2: w_byte = w_ld[23:16];
            2'd3: w_byte = w_ld[31:24];
            default: w_byte = w_ld[7:0];
        endcase
        w_half = r_addrlo[1] ? w_ld[31:16] : w_ld[15:0];
        w_ext  = r_alures;
        case (r_memop)
            OP_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_ext = {24'd0, w_byte};
            OP_LH:   w_ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_ext = {16'd0, w_half};
            OP_LW:   w_ext = w_ld;
            default: w_ext = r_alures;
        endcase
    end

    assign w_adel = r_valid &
                    ((((r_memop == OP_LH) || (r_memop == OP_LHU)) && r_addrlo[0]) ||
                     ((r_memop == OP_LW) && (r_addrlo != 2'd0)));

    assign wb_wdata = w_ext;
    assign wb_we    = r_valid & r_we & ~w_adel & (r_waddr != 5'd0);
    assign wb_waddr = r_waddr;
    assign wb_adel  = w_adel;
endmodule
